// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared definitions for the UART receive path:
//   - rx_state_t : receiver FSM state encodings (also driven out on o_state)
//   - LINE_IDLE  : idle level of the serial line, common with uart_tx
//   - clks_per_bit(): integer (truncating) clocks-per-bit calculation
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    function automatic int clks_per_bit(input int clk_rate_hz, input int baud_rate);
        return clk_rate_hz / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// uart_rx_sync_2ff
// Generic two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so the synchronized output shows a known
// level straight out of reset (idle-high for a UART line).
// Ports:
//   i_clk   : destination clock
//   i_reset : synchronous, active-high reset
//   i_d     : asynchronous input
//   o_q     : synchronized output (two i_clk cycles of latency)
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// Oversampling UART receiver. The asynchronous line is brought into i_clk
// through a two-flop synchronizer, a start bit is qualified at its middle
// (short low glitches are rejected), data is shifted in LSB first and each
// bit is sampled once per bit period at the end of its count.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit. Without it the frame is
// start + DATA_BITS + stop and o_parity_err is tied low.
//
// Ports:
//   i_clk        : system clock
//   i_reset      : synchronous, active-high reset
//   i_uart_rx    : asynchronous serial line, idle high
//   o_data       : received word, stable while o_valid is high
//   o_valid      : word available
//   i_ready      : consumer accepts
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_overrun    : one-cycle pulse, new word dropped (previous unaccepted)
//   o_parity_err : one-cycle pulse, parity mismatch with a good stop bit
//   o_state      : current FSM state (rx_state_t encoding), for observation
//
// Handshake: a transfer happens in every cycle where o_valid && i_ready.
// o_valid then drops the following cycle unless a new word loads in that
// same cycle. i_ready while o_valid is low has no effect. A word arriving
// while o_valid is high and i_ready low is dropped and flagged o_overrun.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_RATE_HZ = 60_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_parity_err,
    output logic [2:0]           o_state
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE_HZ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
            $error("uart_rx: DATA_BITS must be in 5..8");
        end
    endgenerate

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    uart_rx_sync_2ff #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_uart_rx),
        .o_q     (rx_s)
    );

    assign o_state = state;

`ifndef UART_RX_PARITY_EN
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
            par_bad      <= 1'b0;
`endif
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            // Accepted word retires; a delivery below in the same cycle
            // overrides this and keeps o_valid high.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rx_s != LINE_IDLE) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt == MID_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        state   <= (rx_s == LINE_IDLE) ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == END_CNT) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == END_CNT) begin
                        cnt <= '0;
                        // Even parity: parity bit equals XOR of the data bits.
                        par_bad <= (rx_s != ^shift);
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (cnt == END_CNT) begin
                        cnt <= '0;
                        if (rx_s != LINE_IDLE) begin
                            // Framing error wins over any parity mismatch.
                            o_frame_err <= 1'b1;
                            state       <= ST_BREAK;
                        end else begin
                            state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                o_parity_err <= 1'b1;
                            end else
`endif
                            if (!o_valid || i_ready) begin
                                o_data  <= shift;
                                o_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    // Hold off until the line returns idle so a long low
                    // level is not mistaken for a run of start bits.
                    cnt <= '0;
                    if (rx_s == LINE_IDLE) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx at 10 clocks per bit (1 MHz clock, 100 kbaud).
// Line and i_ready are driven one time unit after a rising edge; DUT
// outputs are observed on the falling edge or one unit after a rising edge.
// Define UART_RX_PARITY_EN for both bench and RTL to cover the parity frame.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       i_clk;
    logic       i_reset;
    logic       i_uart_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_parity_err;
    logic [2:0] o_state;

    int checks;
    int errors;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int frame_cnt;
    int over_cnt;
    int par_cnt;
    int valid_cycles;

    uart_rx #(
        .CLK_RATE_HZ (1_000_000),
        .BAUD_RATE   (100_000),
        .DATA_BITS   (8)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_uart_rx    (i_uart_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_parity_err (o_parity_err),
        .o_state      (o_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- monitor ----------------
    initial begin
        frame_cnt    = 0;
        over_cnt     = 0;
        par_cnt      = 0;
        valid_cycles = 0;
    end

    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (o_valid && i_ready) got_q.push_back(o_data);
            if (o_valid)      valid_cycles = valid_cycles + 1;
            if (o_frame_err)  frame_cnt    = frame_cnt + 1;
            if (o_overrun)    over_cnt     = over_cnt + 1;
            if (o_parity_err) par_cnt      = par_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Compare every accepted word against the expected queue, in order.
    task automatic drain(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [7:0] g;
            logic [7:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int k);
        repeat (k) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drives one frame, entered one unit after a rising edge. With
    // ready_pulse set, i_ready is high only for the cycle that ends at the
    // DUT's stop-bit sample edge (start edge + 3 sync/detect clocks + mid
    // start + whole bits).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_bit, input bit ready_pulse);
        logic [10:0] bits;
        int nbits;
        int stop_n;
        int n;
`ifdef UART_RX_PARITY_EN
        bits  = {stop_bit, par_bit, data, 1'b0};
        nbits = 11;
`else
        bits  = {par_bit, stop_bit, data, 1'b0};
        nbits = 10;
`endif
        stop_n = (nbits - 1) * CPB + 8;
        n = 0;
        for (int b = 0; b < nbits; b++) begin
            i_uart_rx = bits[b];
            repeat (CPB) begin
                @(posedge i_clk);
                #1;
                n = n + 1;
                if (ready_pulse) begin
                    if (n == stop_n - 1) i_ready = 1'b1;
                    else if (n == stop_n) i_ready = 1'b0;
                end
            end
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int f0;
        int o0;
        int p0;
        int v0;
        checks    = 0;
        errors    = 0;
        i_reset   = 1'b1;
        i_uart_rx = 1'b1;
        i_ready   = 1'b0;
        tick(3);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_state", o_state, 0);
        check("rst_pulses", {o_frame_err, o_overrun, o_parity_err}, 0);
        i_reset = 1'b0;
        tick(5);

        // 1) single byte, consumer always ready
        f0 = frame_cnt; o0 = over_cnt; p0 = par_cnt; v0 = valid_cycles;
        i_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, even_par(8'hA5), 1'b0);
        tick(5);
        check("a5_valid_cycles", valid_cycles - v0, 1);
        check("a5_errs", (frame_cnt - f0) + (over_cnt - o0) + (par_cnt - p0), 0);
        drain("a5");

        // 2) 3-clock glitch then a real byte
        v0 = valid_cycles;
        i_uart_rx = 1'b0;
        tick(3);
        i_uart_rx = 1'b1;
        tick(20);
        check("glitch_state", o_state, 0);
        check("glitch_no_valid", valid_cycles - v0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, even_par(8'h3C), 1'b0);
        tick(5);
        drain("3c");

        // 3) framing error, held-low break, then recovery
        f0 = frame_cnt; v0 = valid_cycles;
        send_frame(8'h55, 1'b0, even_par(8'h55), 1'b0);
        tick(40);
        check("break_state", o_state, 5);
        check("ferr_count", frame_cnt - f0, 1);
        check("ferr_no_valid", valid_cycles - v0, 0);
        i_uart_rx = 1'b1;
        tick(20);
        check("break_exit_state", o_state, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, even_par(8'h81), 1'b0);
        tick(5);
        check("ferr_count_after", frame_cnt - f0, 1);
        drain("81");

        // 4) overrun: consumer stalled across two bytes
        o0 = over_cnt;
        i_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, even_par(8'h11), 1'b0);
        send_frame(8'h22, 1'b1, even_par(8'h22), 1'b0);
        tick(3);
        check("ovr_valid", o_valid, 1);
        check("ovr_data_held", o_data, 8'h11);
        check("ovr_count", over_cnt - o0, 1);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        check("ovr_valid_fall", o_valid, 0);
        drain("ovr");

        // 5) back-to-back, accept and reload in the same cycle
        o0 = over_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, even_par(8'h00), 1'b0);
        check("b2b_first_valid", o_valid, 1);
        v0 = valid_cycles;
        send_frame(8'hFF, 1'b1, even_par(8'hFF), 1'b1);
        check("b2b_valid_continuous", valid_cycles - v0, 10 * CPB + ((dut.CLKS_PER_BIT == CPB) ? 0 : 1000));
        check("b2b_data", o_data, 8'hFF);
        check("b2b_no_overrun", over_cnt - o0, 0);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        tick(2);
        check("b2b_valid_fall", o_valid, 0);
        drain("b2b");

`ifdef UART_RX_PARITY_EN
        // 6) parity mismatch drops the byte; correct parity delivers it
        p0 = par_cnt; v0 = valid_cycles;
        i_ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        tick(5);
        check("par_err_count", par_cnt - p0, 1);
        check("par_err_no_valid", valid_cycles - v0, 0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        tick(5);
        check("par_ok_count", par_cnt - p0, 1);
        drain("par");
`endif

        // 7) reset in the middle of a frame, with a word pending
        f0 = frame_cnt; o0 = over_cnt; p0 = par_cnt;
        i_ready = 1'b0;
        send_frame(8'h5A, 1'b1, even_par(8'h5A), 1'b0);
        tick(5);
        check("pre_rst_valid", o_valid, 1);
        i_uart_rx = 1'b0;
        tick(CPB);
        i_uart_rx = 1'b1;
        tick(CPB);
        i_uart_rx = 1'b0;
        tick(CPB);
        check("mid_data_state", o_state, 2);
        i_uart_rx = 1'b1;
        i_reset   = 1'b1;
        tick(1);
        i_reset   = 1'b0;
        check("mrst_valid", o_valid, 0);
        check("mrst_data", o_data, 0);
        check("mrst_state", o_state, 0);
        tick(30);
        check("mrst_no_pulses", (frame_cnt - f0) + (over_cnt - o0) + (par_cnt - p0), 0);
        i_ready = 1'b1;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, even_par(8'hC3), 1'b0);
        tick(5);
        drain("c3");

        tick(10);
        check("left_over", got_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
